// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory controller: op encoding,
// FSM state codes, constants and op-classification helpers.
package mem_ctrl_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [31:0] ZERO     = 32'd0;
  localparam logic [4:0]  ZERO_REG = 5'd0;

  function automatic logic op_is_load(input logic [3:0] op);
    logic r;
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    logic r;
    case (op)
      MEM_SB, MEM_SH, MEM_SW: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // Byte ops can never be misaligned; reserved codes are not memory ops.
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic r;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: r = lo[0];
      MEM_LW, MEM_SW:          r = (lo != 2'b00);
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_lane.sv
// mem_lane_align: store-lane replication, byte-enable generation and
// load-lane extraction with sign/zero extension. Purely combinational.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [3:0]  st_op,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  sel,
  output logic [31:0] st_wdata,
  input  logic [3:0]  ld_op,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte enables and replicated store data; loads use the same-size store lanes.
  always_comb begin
    sel      = 4'b0000;
    st_wdata = st_data;
    case (st_op)
      MEM_SB, MEM_LB, MEM_LBU: begin
        sel      = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_SH, MEM_LH, MEM_LHU: begin
        sel      = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      MEM_SW, MEM_LW: begin
        sel      = 4'b1111;
        st_wdata = st_data;
      end
      default: begin
        sel      = 4'b0000;
        st_wdata = st_data;
      end
    endcase
  end

  // Lane extraction and extension of returned read data.
  always_comb begin
    byte_s  = 8'h00;
    half_s  = 16'h0000;
    ld_data = ld_rdata;
    case (ld_addr_lo)
      2'd0:    byte_s = ld_rdata[7:0];
      2'd1:    byte_s = ld_rdata[15:8];
      2'd2:    byte_s = ld_rdata[23:16];
      2'd3:    byte_s = ld_rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (ld_addr_lo[1]) begin
      half_s = ld_rdata[31:16];
    end else begin
      half_s = ld_rdata[15:0];
    end
    case (ld_op)
      MEM_LB:  ld_data = {{24{byte_s[7]}}, byte_s};
      MEM_LBU: ld_data = {24'h000000, byte_s};
      MEM_LH:  ld_data = {{16{half_s[15]}}, half_s};
      MEM_LHU: ld_data = {16'h0000, half_s};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage data-memory controller: one req/ack bus transaction per load or
// store, upstream stall while busy, registered write-back and error pulses.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic              reg_we_i,
  input  logic [DATA_W-1:0] reg_wdata_i,
  output logic              stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [4:0]        reg_waddr_o,
  output logic              reg_we_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              misalign_o,
  output logic              timeout_o
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_r, state_nxt_s;
  logic [7:0]  cnt_r;
  logic [3:0]  op_r;
  logic [1:0]  addr_lo_r;
  logic        is_mem_s, misalign_s, start_s, ack_s, tmo_s, stall_s;
  logic [3:0]  sel_s;
  logic [31:0] st_wdata_s, ld_data_s;

  mem_lane_align u_lane (
    .st_op      (mem_op_i),
    .st_addr_lo (mem_addr_i[1:0]),
    .st_data    (mem_data_i),
    .sel        (sel_s),
    .st_wdata   (st_wdata_s),
    .ld_op      (op_r),
    .ld_addr_lo (addr_lo_r),
    .ld_rdata   (bus_rdata_i),
    .ld_data    (ld_data_s)
  );

  // Next-state and stall decode; ack is only looked at in BUSY.
  always_comb begin
    state_nxt_s = state_r;
    is_mem_s    = op_is_load(mem_op_i) | op_is_store(mem_op_i);
    misalign_s  = is_mem_s & op_misaligned(mem_op_i, mem_addr_i[1:0]);
    start_s     = 1'b0;
    ack_s       = 1'b0;
    tmo_s       = 1'b0;
    stall_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_mem_s && !misalign_s) begin
          start_s     = 1'b1;
          stall_s     = 1'b1;
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (bus_ack_i) begin
          ack_s       = 1'b1;
          state_nxt_s = IDLE;
        end else if (cnt_r == TMO_LAST) begin
          tmo_s       = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          stall_s     = 1'b1;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    // Reset releases the pipeline immediately, even with a memory op presented.
    stall_o = stall_s & ~rst_i;
  end

  // State register and wait-cycle counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == BUSY && !ack_s && !tmo_s) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= 8'd0;
      end
    end
  end

  // Bus-side and write-back registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= 4'b0000;
      bus_wdata_o <= '0;
      reg_waddr_o <= ZERO_REG;
      reg_we_o    <= 1'b0;
      reg_wdata_o <= ZERO;
      misalign_o  <= 1'b0;
      timeout_o   <= 1'b0;
      op_r        <= MEM_NOP;
      addr_lo_r   <= 2'b00;
    end else begin
      misalign_o <= 1'b0;
      timeout_o  <= 1'b0;
      case (state_r)
        IDLE: begin
          reg_waddr_o <= reg_waddr_i;
          if (start_s) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= op_is_store(mem_op_i);
            bus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            bus_sel_o   <= sel_s;
            bus_wdata_o <= st_wdata_s;
            op_r        <= mem_op_i;
            addr_lo_r   <= mem_addr_i[1:0];
            reg_we_o    <= 1'b0;
            reg_wdata_o <= ZERO;
          end else if (misalign_s) begin
            misalign_o  <= 1'b1;
            reg_we_o    <= 1'b0;
            reg_wdata_o <= ZERO;
          end else begin
            reg_we_o    <= reg_we_i;
            reg_wdata_o <= reg_wdata_i;
          end
        end
        BUSY: begin
          if (ack_s) begin
            bus_req_o   <= 1'b0;
            reg_waddr_o <= reg_waddr_i;
            if (op_is_load(op_r)) begin
              reg_we_o    <= reg_we_i;
              reg_wdata_o <= ld_data_s;
            end else begin
              reg_we_o    <= 1'b0;
              reg_wdata_o <= ZERO;
            end
          end else if (tmo_s) begin
            bus_req_o <= 1'b0;
            timeout_o <= 1'b1;
            reg_we_o  <= 1'b0;
          end else begin
            reg_we_o  <= 1'b0;
          end
        end
        default: begin
          bus_req_o <= 1'b0;
          reg_we_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table of transactions with a write-back
// scoreboard, plus a hand-written reset-during-BUSY sequence.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  mem_op_i = 4'd0;
  logic [31:0] mem_addr_i = 32'd0, mem_data_i = 32'd0;
  logic [4:0]  reg_waddr_i = 5'd0;
  logic        reg_we_i = 1'b0;
  logic [31:0] reg_wdata_i = 32'd0;
  logic        stall_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'd0;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o, misalign_o, timeout_o;
  logic [31:0] reg_wdata_o;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, data, alu;
    logic [4:0]  waddr;
    int          waits;
    logic [31:0] rdata;
    logic        bus;
    logic [31:0] e_addr;
    logic [3:0]  e_sel;
    logic        e_bwe, e_bwd_chk;
    logic [31:0] e_bwdata;
    int          e_stall, e_req;
    logic        e_we, e_wd_chk;
    logic [31:0] e_wdata;
    logic        e_mis, e_tmo;
  } vec_t;

  typedef struct {
    logic [4:0]  waddr;
    logic        we, wd_chk;
    logic [31:0] wdata;
    logic        mis, tmo;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[12];

  mem_ctrl #(.TIMEOUT_CYCLES(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   stall_cnt = 0;
    int   req_cnt = 0;
    exp_t e, got;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(posedge clk_i); #1;
    mem_op_i    = v.op;
    mem_addr_i  = v.addr;
    mem_data_i  = v.data;
    reg_waddr_i = v.waddr;
    reg_we_i    = 1'b1;
    reg_wdata_i = v.alu;
    bus_ack_i   = 1'b0;
    e.waddr = v.waddr; e.we = v.e_we; e.wd_chk = v.e_wd_chk;
    e.wdata = v.e_wdata; e.mis = v.e_mis; e.tmo = v.e_tmo;
    sb_q.push_back(e);
    @(negedge clk_i);
    if (stall_o) stall_cnt++;
    if (v.bus) begin
      for (int k = 0; k < 40; k++) begin
        @(posedge clk_i); #1;
        if (k == v.waits) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = v.rdata;
        end
        @(negedge clk_i);
        if (bus_req_o) req_cnt++;
        if (stall_o) stall_cnt++;
        if (k == 0) begin
          chk({tag, "_bus_addr"}, bus_addr_o, v.e_addr);
          chk({tag, "_bus_sel"}, {28'd0, bus_sel_o}, {28'd0, v.e_sel});
          chk({tag, "_bus_we"}, {31'd0, bus_we_o}, {31'd0, v.e_bwe});
          if (v.e_bwd_chk) chk({tag, "_bus_wdata"}, bus_wdata_o, v.e_bwdata);
        end
        if (!stall_o) break;
      end
    end
    @(posedge clk_i); #1;
    bus_ack_i = 1'b0;
    mem_op_i  = MEM_NOP;
    reg_we_i  = 1'b0;
    @(negedge clk_i);
    chk({tag, "_stall_cycles"}, stall_cnt, v.e_stall);
    chk({tag, "_req_cycles"}, req_cnt, v.e_req);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      chk({tag, "_reg_we"}, {31'd0, reg_we_o}, {31'd0, got.we});
      chk({tag, "_reg_waddr"}, {27'd0, reg_waddr_o}, {27'd0, got.waddr});
      if (got.wd_chk) chk({tag, "_reg_wdata"}, reg_wdata_o, got.wdata);
      chk({tag, "_misalign"}, {31'd0, misalign_o}, {31'd0, got.mis});
      chk({tag, "_timeout"}, {31'd0, timeout_o}, {31'd0, got.tmo});
    end
  endtask

  initial begin
    // op, addr, data, alu, waddr, waits, rdata, bus, e_addr, e_sel, e_bwe, e_bwd_chk,
    // e_bwdata, e_stall, e_req, e_we, e_wd_chk, e_wdata, e_mis, e_tmo
    vecs[0]  = '{MEM_NOP, 32'h0000_0000, 32'h0, 32'h0000_0055, 5'd5, 0, 32'h0, 1'b0,
                 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 0, 0, 1'b1, 1'b1, 32'h0000_0055, 1'b0, 1'b0};
    vecs[1]  = '{MEM_LB, 32'h0000_1003, 32'h0, 32'h0, 5'd6, 3, 32'h80FF_0000, 1'b1,
                 32'h0000_1000, 4'b1000, 1'b0, 1'b0, 32'h0, 4, 4, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0};
    vecs[2]  = '{MEM_LHU, 32'h0000_2002, 32'h0, 32'h0, 5'd7, 0, 32'hBEEF_1234, 1'b1,
                 32'h0000_2000, 4'b1100, 1'b0, 1'b0, 32'h0, 1, 1, 1'b1, 1'b1, 32'h0000_BEEF, 1'b0, 1'b0};
    vecs[3]  = '{MEM_SH, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 5'd8, 1, 32'h0, 1'b1,
                 32'h0000_3000, 4'b1100, 1'b1, 1'b1, 32'hABCD_ABCD, 2, 2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[4]  = '{MEM_LW, 32'h0000_4001, 32'h0, 32'h0, 5'd9, 0, 32'h0, 1'b0,
                 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[5]  = '{MEM_SW, 32'h0000_5000, 32'hDEAD_BEEF, 32'h0, 5'd10, 99, 32'h0, 1'b1,
                 32'h0000_5000, 4'b1111, 1'b1, 1'b1, 32'hDEAD_BEEF, 4, 4, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[6]  = '{MEM_LH, 32'h0000_6002, 32'h0, 32'h0, 5'd11, 2, 32'h8001_7FFF, 1'b1,
                 32'h0000_6000, 4'b1100, 1'b0, 1'b0, 32'h0, 3, 3, 1'b1, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0};
    vecs[7]  = '{MEM_LBU, 32'h0000_7001, 32'h0, 32'h0, 5'd12, 0, 32'h0000_F000, 1'b1,
                 32'h0000_7000, 4'b0010, 1'b0, 1'b0, 32'h0, 1, 1, 1'b1, 1'b1, 32'h0000_00F0, 1'b0, 1'b0};
    vecs[8]  = '{MEM_SB, 32'h0000_8002, 32'h0000_00A5, 32'h0, 5'd13, 0, 32'h0, 1'b1,
                 32'h0000_8000, 4'b0100, 1'b1, 1'b1, 32'hA5A5_A5A5, 1, 1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[9]  = '{MEM_SH, 32'h0000_9001, 32'h0000_1111, 32'h0, 5'd14, 0, 32'h0, 1'b0,
                 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[10] = '{MEM_LW, 32'h0000_A000, 32'h0, 32'h0, 5'd15, 3, 32'h1234_5678, 1'b1,
                 32'h0000_A000, 4'b1111, 1'b0, 1'b0, 32'h0, 4, 4, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0};
    vecs[11] = '{MEM_NOP, 32'h0000_B003, 32'h0, 32'h0000_CAFE, 5'd16, 0, 32'h0, 1'b0,
                 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 0, 0, 1'b1, 1'b1, 32'h0000_CAFE, 1'b0, 1'b0};

    #2;
    chk("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
    chk("rst_reg_we", {31'd0, reg_we_o}, 32'd0);
    chk("rst_reg_wdata", reg_wdata_o, 32'd0);
    chk("rst_bus_addr", bus_addr_o, 32'd0);
    chk("rst_flags", {30'd0, misalign_o, timeout_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset asserted mid-transaction, then a stale ack.
    @(posedge clk_i); #1;
    mem_op_i = MEM_LW; mem_addr_i = 32'h0000_C000; reg_waddr_i = 5'd3; reg_we_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("mid_busy_req", {31'd0, bus_req_o}, 32'd1);
    #1 rst_i = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    chk("mid_rst_reg_we", {31'd0, reg_we_o}, 32'd0);
    @(posedge clk_i); #1;
    mem_op_i = MEM_NOP; reg_we_i = 1'b0; rst_i = 1'b0;
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    chk("late_ack_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
    bus_ack_i = 1'b0;
    @(negedge clk_i);
    chk("late_ack_reg_we", {31'd0, reg_we_o}, 32'd0);
    chk("late_ack_req", {31'd0, bus_req_o}, 32'd0);

    run_vec(12, vecs[2]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
